// File: rtl/lcd_bus_ctrl_if.sv
// Avalon-MM register port of the character-LCD bus controller.
// The FSM state is also carried here so checkers can bind to it.
interface lcd_bus_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  state_dbg;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, state_dbg
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, state_dbg
    );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style character-LCD bus sequencer behind an Avalon-MM slave:
// one register write performs one complete LCD transfer, optionally followed by busy polling.
module lcd_bus_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int POLL_MAX  = 4095
) (
    input  logic           clk,
    input  logic           reset,
    lcd_bus_ctrl_if.slave  bus,
    inout  wire  [7:0]     lcd_data,
    output logic           lcd_rs,
    output logic           lcd_rw,
    output logic           lcd_en
);

    // Handshake: there is no waitrequest. A write is taken on every clk where
    // chipselect && !write_n; readdata follows address one clk later, whatever read_n is.

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        EN_HI      = 3'd2,
        HOLD       = 3'd3,
        POLL_SETUP = 3'd4,
        POLL_EN    = 3'd5,
        POLL_HOLD  = 3'd6
    } state_t;

    localparam logic [7:0]  SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  EN_LD    = 8'(EN_CYC - 1);
    localparam logic [7:0]  HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [11:0] POLL_LIM = 12'(POLL_MAX);

    state_t      state;
    logic [7:0]  cnt;
    logic [11:0] poll_cnt;
    logic        is_read;
    logic        busy_flag;
    logic        lcd_oe;
    logic [7:0]  dout;
    logic [7:0]  last_rd;
    logic        poll_en;
    logic        overrun;
    logic        timeout;

    logic        wr_acc;
    logic        start_req;
    logic        ctl_wr;
    logic        busy;
    logic        unused_bits;

    assign wr_acc      = bus.chipselect & ~bus.write_n;
    assign start_req   = wr_acc & (bus.address != 2'd3);
    assign ctl_wr      = wr_acc & (bus.address == 2'd3);
    assign busy        = (state != IDLE);
    assign bus.state_dbg = state;
    assign unused_bits = ^{bus.read_n, bus.writedata[31:8]};

    // The bus enable is a flop with async reset, so reset floats the bus at once.
    assign lcd_data = lcd_oe ? dout : 8'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            poll_cnt  <= '0;
            is_read   <= 1'b0;
            busy_flag <= 1'b0;
            dout      <= '0;
            lcd_oe    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_en    <= 1'b0;
            last_rd   <= '0;
            poll_en   <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (ctl_wr) begin
                poll_en <= bus.writedata[0];
                if (bus.writedata[1]) begin
                    overrun <= 1'b0;
                    timeout <= 1'b0;
                end
            end
            // A start that lands while busy (including the final HOLD cycle) is lost.
            if (start_req && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_req) begin
                        state    <= SETUP;
                        cnt      <= SETUP_LD;
                        poll_cnt <= '0;
                        is_read  <= (bus.address == 2'd2);
                        lcd_rs   <= (bus.address == 2'd1) |
                                    ((bus.address == 2'd2) & bus.writedata[0]);
                        lcd_rw   <= (bus.address == 2'd2);
                        lcd_oe   <= (bus.address != 2'd2);
                        dout     <= bus.writedata[7:0];
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        state  <= EN_HI;
                        cnt    <= EN_LD;
                        lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                EN_HI: begin
                    if (cnt == 8'd0) begin
                        state  <= HOLD;
                        cnt    <= HOLD_LD;
                        lcd_en <= 1'b0;
                        if (is_read)
                            last_rd <= lcd_data;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        lcd_oe <= 1'b0;
                        if (!is_read && poll_en) begin
                            state  <= POLL_SETUP;
                            cnt    <= SETUP_LD;
                            lcd_rs <= 1'b0;
                            lcd_rw <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            lcd_rw <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                POLL_SETUP: begin
                    if (cnt == 8'd0) begin
                        state  <= POLL_EN;
                        cnt    <= EN_LD;
                        lcd_en <= 1'b1;
                        if (poll_cnt != 12'hFFF)
                            poll_cnt <= poll_cnt + 12'd1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                POLL_EN: begin
                    if (cnt == 8'd0) begin
                        state     <= POLL_HOLD;
                        cnt       <= HOLD_LD;
                        lcd_en    <= 1'b0;
                        busy_flag <= lcd_data[7];
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                POLL_HOLD: begin
                    if (cnt == 8'd0) begin
                        if (busy_flag && (poll_cnt < POLL_LIM)) begin
                            state <= POLL_SETUP;
                            cnt   <= SETUP_LD;
                        end else begin
                            state  <= IDLE;
                            lcd_rw <= 1'b0;
                            if (busy_flag)
                                timeout <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    lcd_en <= 1'b0;
                    lcd_oe <= 1'b0;
                    lcd_rw <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                2'd0:    bus.readdata <= {24'h0, last_rd};
                2'd1:    bus.readdata <= 32'h0;
                2'd2:    bus.readdata <= {28'h0, poll_en, timeout, overrun, busy};
                default: bus.readdata <= {31'h0, poll_en};
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: a default-parameter instance and a POLL_MAX=3 instance,
// each with a small LCD model answering reads and busy-flag polls.
module tb_lcd_bus_ctrl;

    logic clk;
    logic reset;

    // shared Avalon driver variables, steered to one instance by sel
    int          sel;
    logic [1:0]  address;
    logic        cs;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;

    lcd_bus_ctrl_if bus0 ();
    lcd_bus_ctrl_if bus1 ();

    assign bus0.address    = address;
    assign bus0.chipselect = cs & (sel == 0);
    assign bus0.write_n    = write_n;
    assign bus0.read_n     = read_n;
    assign bus0.writedata  = writedata;
    assign bus1.address    = address;
    assign bus1.chipselect = cs & (sel == 1);
    assign bus1.write_n    = write_n;
    assign bus1.read_n     = read_n;
    assign bus1.writedata  = writedata;

    wire  [7:0] lcd_data0;
    wire  [7:0] lcd_data1;
    logic       lcd_rs0, lcd_rw0, lcd_en0;
    logic       lcd_rs1, lcd_rw1, lcd_en1;

    lcd_bus_ctrl dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0),
        .lcd_data (lcd_data0),
        .lcd_rs   (lcd_rs0),
        .lcd_rw   (lcd_rw0),
        .lcd_en   (lcd_en0)
    );

    lcd_bus_ctrl #(.POLL_MAX(3)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus1),
        .lcd_data (lcd_data1),
        .lcd_rs   (lcd_rs1),
        .lcd_rw   (lcd_rw1),
        .lcd_en   (lcd_en1)
    );

    // LCD models: drive the bus while RW=1; DB7 set for the first busy_polls read strobes
    logic [7:0] rd_byte0, rd_byte1, model0, model1;
    int strobes0, strobes1, rises0, rises1;
    int sbase0, sbase1, busy_polls0, busy_polls1;

    assign model0 = rd_byte0 | (((strobes0 - sbase0) >= 1 && (strobes0 - sbase0) <= busy_polls0) ? 8'h80 : 8'h00);
    assign model1 = rd_byte1 | (((strobes1 - sbase1) >= 1 && (strobes1 - sbase1) <= busy_polls1) ? 8'h80 : 8'h00);
    assign lcd_data0 = lcd_rw0 ? model0 : 8'bz;
    assign lcd_data1 = lcd_rw1 ? model1 : 8'bz;

    always @(posedge lcd_en0) begin
        rises0 = rises0 + 1;
        if (lcd_rw0) strobes0 = strobes0 + 1;
    end
    always @(posedge lcd_en1) begin
        rises1 = rises1 + 1;
        if (lcd_rw1) strobes1 = strobes1 + 1;
    end

    // observation of the selected instance
    logic        en_s, rs_s, rw_s, oe_s;
    logic [7:0]  data_s;
    logic [31:0] rdata_s;
    logic [2:0]  st_s;
    assign en_s    = (sel == 0) ? lcd_en0 : lcd_en1;
    assign rs_s    = (sel == 0) ? lcd_rs0 : lcd_rs1;
    assign rw_s    = (sel == 0) ? lcd_rw0 : lcd_rw1;
    assign oe_s    = (sel == 0) ? dut0.lcd_oe : dut1.lcd_oe;
    assign data_s  = (sel == 0) ? lcd_data0 : lcd_data1;
    assign rdata_s = (sel == 0) ? bus0.readdata : bus1.readdata;
    assign st_s    = (sel == 0) ? bus0.state_dbg : bus1.state_dbg;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int total;
    int bad;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks: enter and leave 1 time unit after a rising clk edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs        = 1'b1;
        write_n   = 1'b0;
        @(posedge clk); #1;
        cs      = 1'b0;
        write_n = 1'b1;
        address = 2'd2;
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        cs      = 1'b1;
        read_n  = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        cs     = 1'b0;
        read_n = 1'b1;
        if (exp_q.size() > 0)
            check(name, rdata_s, exp_q.pop_front());
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (st_s == 3'd0) begin
                cyc = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0] addr;
        logic [7:0] wbyte;
        logic [7:0] rd_byte;
        logic       exp_rs;
        logic       exp_rw;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int k);
        vec_t v;
        logic exp_en;
        v = vecs[k];
        rd_byte0    = v.rd_byte;
        busy_polls0 = 0;
        sbase0      = strobes0;
        bus_write(v.addr, {24'h0, v.wbyte});
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            exp_en = (i >= 3 && i <= 14);
            check($sformatf("v%0d c%0d en", k, i), {31'h0, en_s}, {31'h0, exp_en});
            check($sformatf("v%0d c%0d rs", k, i), {31'h0, rs_s}, {31'h0, v.exp_rs});
            check($sformatf("v%0d c%0d rw", k, i), {31'h0, rw_s}, {31'h0, (i <= 16) ? v.exp_rw : 1'b0});
            check($sformatf("v%0d c%0d oe", k, i), {31'h0, oe_s}, {31'h0, (i <= 16) ? v.exp_oe : 1'b0});
            if (i <= 16 && v.exp_oe)
                check($sformatf("v%0d c%0d data", k, i), {24'h0, data_s}, {24'h0, v.wbyte});
            if (i >= 2)
                check($sformatf("v%0d c%0d status", k, i), rdata_s, (i <= 17) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        if (v.exp_rw)
            exp_last = v.rd_byte;
        read_reg(2'd0, {24'h0, exp_last}, $sformatf("v%0d last_rd", k));
    endtask

    int cyc;
    int rbase;

    initial begin
        total = 0; bad = 0; sel = 0;
        address = 2'd0; cs = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = '0;
        rd_byte0 = 8'h00; rd_byte1 = 8'h00;
        strobes0 = 0; strobes1 = 0; rises0 = 0; rises1 = 0;
        sbase0 = 0; sbase1 = 0; busy_polls0 = 0; busy_polls1 = 0;
        exp_last = 8'h00;

        vecs[0] = '{addr: 2'd0, wbyte: 8'h38, rd_byte: 8'h00, exp_rs: 1'b0, exp_rw: 1'b0, exp_oe: 1'b1};
        vecs[1] = '{addr: 2'd1, wbyte: 8'h41, rd_byte: 8'h00, exp_rs: 1'b1, exp_rw: 1'b0, exp_oe: 1'b1};
        vecs[2] = '{addr: 2'd2, wbyte: 8'h01, rd_byte: 8'h5A, exp_rs: 1'b1, exp_rw: 1'b1, exp_oe: 1'b0};
        vecs[3] = '{addr: 2'd2, wbyte: 8'h00, rd_byte: 8'hA5, exp_rs: 1'b0, exp_rw: 1'b1, exp_oe: 1'b0};
        vecs[4] = '{addr: 2'd1, wbyte: 8'($urandom_range(0, 255)), rd_byte: 8'h00, exp_rs: 1'b1, exp_rw: 1'b0, exp_oe: 1'b1};
        vecs[5] = '{addr: 2'd0, wbyte: 8'($urandom_range(0, 255)), rd_byte: 8'h00, exp_rs: 1'b0, exp_rw: 1'b0, exp_oe: 1'b1};

        // reset state of both instances
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check($sformatf("rst%0d readdata", s), rdata_s, 32'h0);
            check($sformatf("rst%0d en", s), {31'h0, en_s}, 32'h0);
            check($sformatf("rst%0d rs", s), {31'h0, rs_s}, 32'h0);
            check($sformatf("rst%0d rw", s), {31'h0, rw_s}, 32'h0);
            check($sformatf("rst%0d oe", s), {31'h0, oe_s}, 32'h0);
            check($sformatf("rst%0d state", s), {29'h0, st_s}, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        sel = 0;
        read_reg(2'd2, 32'h0, "status0 after reset");
        sel = 1;
        read_reg(2'd2, 32'h0, "status1 after reset");
        sel = 0;

        // table-driven single transfers, polling off
        for (int k = 0; k < 6; k++)
            run_vec(k);
        read_reg(2'd1, 32'h0, "addr1 read");
        read_reg(2'd3, 32'h0, "addr3 read");

        // start write on the last HOLD cycle is dropped and flags overrun
        rbase = rises0;
        bus_write(2'd1, 32'h11);
        repeat (15) @(negedge clk);
        @(posedge clk); #1;
        bus_write(2'd1, 32'h22);
        @(negedge clk);
        check("drop state", {29'h0, st_s}, 32'h0);
        check("drop en", {31'h0, en_s}, 32'h0);
        @(posedge clk); #1;
        read_reg(2'd2, 32'h2, "drop overrun");
        repeat (20) @(posedge clk);
        #1;
        check("drop strobes", rises0 - rbase, 1);
        bus_write(2'd3, 32'h2);
        read_reg(2'd2, 32'h0, "overrun cleared");

        // busy flag set for 3 polls, clear on the 4th
        bus_write(2'd3, 32'h1);
        rd_byte0 = 8'h00; busy_polls0 = 3; sbase0 = strobes0;
        bus_write(2'd0, 32'h01);
        wait_idle(400, cyc);
        check("poll cycles", cyc, 81);
        check("poll strobes", strobes0 - sbase0, 4);
        read_reg(2'd2, 32'h8, "poll status");
        read_reg(2'd0, {24'h0, exp_last}, "poll keeps last_rd");
        read_reg(2'd3, 32'h1, "poll_en read");

        // POLL_MAX=3 instance with DB7 stuck high
        sel = 1;
        bus_write(2'd3, 32'h1);
        rd_byte1 = 8'h00; busy_polls1 = 100000; sbase1 = strobes1;
        bus_write(2'd1, 32'h20);
        wait_idle(400, cyc);
        check("timeout cycles", cyc, 65);
        check("timeout strobes", strobes1 - sbase1, 3);
        read_reg(2'd2, 32'hC, "timeout status");
        bus_write(2'd3, 32'h3);
        read_reg(2'd2, 32'h8, "timeout cleared");

        // overrun during a transfer, then reset in the middle of EN_HI
        sel = 0;
        bus_write(2'd3, 32'h2);
        bus_write(2'd1, 32'h55);
        bus_write(2'd1, 32'h66);
        read_reg(2'd2, 32'h3, "overrun busy status");
        @(negedge clk);
        check("mid en", {31'h0, en_s}, 32'h1);
        check("mid data", {24'h0, data_s}, 32'h55);
        check("mid oe", {31'h0, oe_s}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async rst en", {31'h0, en_s}, 32'h0);
        check("async rst oe", {31'h0, oe_s}, 32'h0);
        check("async rst rw", {31'h0, rw_s}, 32'h0);
        check("async rst state", {29'h0, st_s}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_last = 8'h00;
        read_reg(2'd2, 32'h0, "status after reset");
        read_reg(2'd0, {24'h0, exp_last}, "last_rd after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_ctrl.md
Name: lcd_bus_ctrl

Overview:
Avalon-MM slave that sequences HD44780-style character-LCD bus transfers for the Nios II system. It handles instruction writes, data writes and register reads. It generates RS/RW/E timing from clock-cycle parameters and drives the 8-bit bidirectional data bus. It optionally polls the LCD busy flag after each write, so software issues one register write per LCD operation and never bit-bangs the port.

Parameters:
SETUP_CYC, 2, cycles RS/RW/data are stable before E rises (tAS); range 1..15
EN_CYC, 12, cycles E is held high (PW_EH); range 1..255
HOLD_CYC, 2, cycles RS/RW/data are held after E falls (tH); range 1..15
POLL_MAX, 4095, maximum busy-flag reads per poll sequence before timeout

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
read_n  input  1  active-low read strobe (readdata is valid regardless)
writedata  input  32  write data
readdata  output  32  registered read data
lcd_data  inout  8  LCD DB[7:0]
lcd_rs  output  1  register select
lcd_rw  output  1  1 = read, 0 = write
lcd_en  output  1  enable strobe

Behaviour:
- Reset (asynchronous, active-high): readdata=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=Z, state IDLE, all counters 0, last_rd=0, poll_en=0, overrun=0, timeout=0.
- Register map:
  - addr0 W: start instruction write (RS=0, byte=writedata[7:0]). R: {24'b0,last_rd}.
  - addr1 W: start data write (RS=1). R: 0.
  - addr2 W: start read, RS=writedata[0]. R: {28'b0, poll_en, timeout, overrun, busy}.
  - addr3 W: bit0 sets poll_en; bit1=1 clears overrun and timeout. R: {31'b0, poll_en}.
- readdata is registered every clk from an address mux, so it has 1-cycle latency.
- busy=1 whenever state != IDLE.
- Start writes (addr0/1/2) are accepted only in IDLE. A start write arriving while busy is dropped and sets overrun (sticky).
- An addr3 write is always accepted.
- FSM states: IDLE -> SETUP -> EN_HI -> HOLD -> (POLL_SETUP -> POLL_EN -> POLL_HOLD)* -> IDLE.
- A single down-counter is loaded on each state entry.
- SETUP (SETUP_CYC cycles): lcd_rs and lcd_rw driven, lcd_en=0. For writes, lcd_data drives the latched byte.
- EN_HI (EN_CYC cycles): lcd_en=1. For a read, lcd_data is sampled into last_rd on the final EN_HI cycle.
- HOLD (HOLD_CYC cycles): lcd_en=0, RS/RW/data held.
- Exit from HOLD:
  - Write with poll_en=1: go to POLL_SETUP.
  - Otherwise: go to IDLE.
- Poll phase:
  - POLL_* states reuse the same timings with RS=0 and RW=1.
  - Bus is released (Z) from POLL_SETUP onward.
  - DB7 is sampled on the last POLL_EN cycle; the poll does not update last_rd.
  - DB7=0: go to IDLE.
  - DB7=1 with poll count < POLL_MAX: go to POLL_SETUP again.
  - DB7=1 with poll count = POLL_MAX: set timeout (sticky) and go to IDLE.
- lcd_data is driven only while lcd_rw=0 within a write transfer (SETUP/EN_HI/HOLD). It is Z in IDLE and in every read/poll state. There is no same-cycle turnaround: RW changes only at a SETUP entry.
- In IDLE: lcd_en=0, lcd_rw=0, lcd_rs holds its last value, bus is Z.
- Simultaneous start write and transfer completion in the same cycle: the FSM is not yet IDLE, so the start write is dropped and overrun is set.
- Reset mid-transfer: lcd_en drops to 0 and the bus goes Z immediately (asynchronously). No partial transfer resumes.
- Poll count is 12 bits, saturating, and cleared at each transfer start.
- Timing with defaults: a transfer occupies SETUP+EN+HOLD = 16 cycles, so busy reads 0 on the 17th cycle after acceptance (no poll).

Test Plan:
- Write addr0=0x38 with poll_en=0 -> lcd_rs=0, lcd_rw=0, lcd_data=0x38 for 2 cycles before lcd_en rises; lcd_en high exactly 12 cycles; data held 2 cycles after fall, then Z; status busy=1 during transfer, 0 afterwards.
- Write addr1=0x41 -> same sequence with lcd_rs=1; bus value 0x41 throughout SETUP/EN_HI/HOLD.
- LCD model drives 0x5A; write addr2=1 -> lcd_rw=1, bus never driven by DUT; read addr0 one cycle later -> readdata=0x0000005A.
- poll_en=1; LCD model returns DB7=1 for 3 polls, then 0 -> after the write, exactly 4 poll strobes follow, then IDLE; timeout=0.
- poll_en=1, POLL_MAX=3, DB7 stuck at 1 -> 3 poll strobes, then IDLE with status=0x0000000C (poll_en=1, timeout=1); writing addr3=0x3 clears timeout, giving status=0x8.
- Write addr1 during a transfer, then assert reset mid-EN_HI -> overrun=1 before reset; on reset, lcd_en=0 and bus=Z immediately, and status=0 after reset.
